// File: rtl/rgb565_gray_pkg.sv
// rgb565_gray_pkg: shared state encoding and luma coefficients for the RGB565 gray sequencer
package rgb565_gray_pkg;
  typedef enum logic [1:0] {IDLE, CONV, RESP} state_t;
  localparam logic [7:0] COEF_R = 8'd54;
  localparam logic [7:0] COEF_G = 8'd183;
  localparam logic [7:0] COEF_B = 8'd19;
  localparam logic [7:0] READ_SUM_OFFSET = 8'd1;
endpackage

// File: rtl/rgb565_gray_pixel.sv
// rgb565_gray_pixel: combinational RGB565 to 8-bit luma conversion
module rgb565_gray_pixel
  import rgb565_gray_pkg::*;
(
  input  logic [15:0] rgb,
  output logic [7:0]  gray
);
  logic [15:0] r8, g8, b8, sum;
  assign r8 = {8'd0, rgb[15:11], 3'b0};
  assign g8 = {8'd0, rgb[10:5], 2'b0};
  assign b8 = {8'd0, rgb[4:0], 3'b0};
  // Full-scale white sums to 64220, so 16 bits never overflow
  assign sum = r8 * {8'd0, COEF_R} + g8 * {8'd0, COEF_G} + b8 * {8'd0, COEF_B};
  assign gray = sum[15:8];
endmodule

// File: rtl/rgb565_gray_sequencer.sv
// rgb565_gray_sequencer: four-pixel RGB565 to gray custom instruction with a saturating brightness sum
module rgb565_gray_sequencer
  import rgb565_gray_pkg::*;
#(
  parameter logic [7:0] customInstructionId = 8'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  iseId,
  input  logic [31:0] valueA,
  input  logic [31:0] valueB,
  output logic        done,
  output logic [31:0] result
);
  localparam logic [7:0] READ_ID = customInstructionId + READ_SUM_OFFSET;
  state_t state_q, state_d;
  logic [63:0] pix_q, pix_d;
  logic [1:0] idx_q, idx_d;
  logic [31:0] acc_q, acc_d, sum_q, sum_d, result_q, result_d;
  logic done_q, done_d;
  logic is_conv, is_read;
  logic [15:0] cur_pix;
  logic [7:0] gray;
  logic [32:0] sum_wide;
  assign is_conv = start && iseId == customInstructionId;
  assign is_read = start && iseId == READ_ID;
  assign cur_pix = pix_q[{idx_q, 4'b0} +: 16];
  rgb565_gray_pixel u_pixel (.rgb(cur_pix), .gray(gray));
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      pix_q    <= '0;
      idx_q    <= '0;
      acc_q    <= '0;
      sum_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pix_q    <= pix_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      sum_q    <= sum_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end
  always_comb begin
    state_d = state_q == IDLE ? (is_conv ? CONV : is_read ? RESP : IDLE) :
              state_q == CONV ? (idx_q == 2'd3 ? RESP : CONV) : IDLE;
  end
  always_comb begin
    pix_d = state_q == IDLE && is_conv ? {valueB, valueA} : pix_q;
    idx_d = state_q == CONV ? idx_q + 2'd1 : 2'd0;
    acc_d = acc_q;
    if (state_q == CONV) acc_d[{idx_q, 3'b0} +: 8] = gray;
    sum_wide = {1'b0, sum_q} + {25'd0, gray};
    sum_d = state_q == IDLE && is_read ? 32'd0 :
            state_q == CONV ? (sum_wide[32] ? 32'hFFFF_FFFF : sum_wide[31:0]) : sum_q;
    done_d = state_d == RESP;
    // The result register only holds data in the done cycle so the port reads zero otherwise
    result_d = state_q == IDLE && is_read ? sum_q :
               state_q == CONV && state_d == RESP ? acc_d : 32'd0;
  end
  assign done = done_q;
  assign result = result_q;
endmodule

// File: tb/tb_rgb565_gray_sequencer.sv
// tb_rgb565_gray_sequencer: randomized self-checking bench against a luma/sum reference model
module tb_rgb565_gray_sequencer;
  localparam logic [7:0] CID = 8'hFF;
  localparam logic [7:0] RID = 8'h00;
  localparam logic [7:0] BAD = 8'h01;
  logic clk = 1'b0, reset, start, done;
  logic [7:0] iseId;
  logic [31:0] valueA, valueB, result;
  int n_vec = 0, n_err = 0;
  longint m_sum = 0;
  always #5 clk = ~clk;
  rgb565_gray_sequencer #(.customInstructionId(CID)) dut (
    .clock(clk), .reset(reset), .start(start), .iseId(iseId),
    .valueA(valueA), .valueB(valueB), .done(done), .result(result)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] ref_gray(input logic [15:0] p);
    int r, g, b;
    r = int'(p[15:11]) * 8;
    g = int'(p[10:5]) * 4;
    b = int'(p[4:0]) * 8;
    return 8'((r * 54 + g * 183 + b * 19) / 256);
  endfunction
  function automatic logic [31:0] ref_conv(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] px;
    logic [31:0] o;
    px = {b, a};
    for (int k = 0; k < 4; k++) begin
      o[8*k +: 8] = ref_gray(px[16*k +: 16]);
      m_sum = m_sum + longint'(o[8*k +: 8]);
      if (m_sum > 64'hFFFF_FFFF) m_sum = 64'hFFFF_FFFF;
    end
    return o;
  endfunction
  task automatic op(input logic [7:0] id, input logic [31:0] a, input logic [31:0] b,
                    input int glitch, output logic [31:0] res, output int lat);
    iseId = id; valueA = a; valueB = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; lat = 0; res = 32'd0;
    for (int i = 1; i <= 12 && lat == 0; i++) begin
      start = i == glitch;
      if (i == glitch) begin valueA = ~a; valueB = ~b; iseId = CID; end
      if (done) begin lat = i; res = result; end
      else @(negedge clk);
    end
    start = 1'b0;
  endtask
  task automatic do_conv(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input int glitch, output logic [31:0] res);
    logic [31:0] exp;
    int lat;
    exp = ref_conv(a, b);
    op(CID, a, b, glitch, res, lat);
    chk({tag, "_lat"}, 32'(lat), 32'd5);
    chk(tag, res, exp);
    @(negedge clk);
    chk({tag, "_done_low"}, {31'd0, done}, 32'd0);
    chk({tag, "_res_zero"}, result, 32'd0);
  endtask
  task automatic do_read(input string tag, output logic [31:0] res);
    logic [31:0] exp;
    int lat;
    exp = m_sum[31:0];
    m_sum = 0;
    op(RID, $urandom, $urandom, 0, res, lat);
    chk({tag, "_lat"}, 32'(lat), 32'd1);
    chk(tag, res, exp);
    @(negedge clk);
    chk({tag, "_done_low"}, {31'd0, done}, 32'd0);
  endtask
  task automatic do_bad(input string tag);
    logic [31:0] res;
    int lat;
    op(BAD, $urandom, $urandom, 0, res, lat);
    chk({tag, "_lat"}, 32'(lat), 32'd0);
    chk({tag, "_res"}, result, 32'd0);
  endtask
  initial begin
    logic [31:0] r;
    int n_done;
    reset = 1'b1; start = 1'b0; iseId = 8'd0; valueA = '0; valueB = '0;
    repeat (3) @(negedge clk);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    do_conv("tp_conv", 32'hF800_FFFF, 32'h001F_07E0, 0, r);
    chk("tp_conv_const", r, 32'h12B4_34FA);
    do_read("tp_sum", r);
    chk("tp_sum_const", r, 32'd500);
    do_read("tp_sum_again", r);
    chk("tp_sum_again_const", r, 32'd0);
    do_conv("pre_bad", 32'h1234_5678, 32'h9ABC_DEF0, 0, r);
    do_bad("bad_id");
    do_read("after_bad", r);
    iseId = CID; valueA = 32'hFFFF_FFFF; valueB = 32'hFFFF_FFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_sum = 0;
    n_done = 0;
    repeat (8) begin
      if (done) n_done++;
      @(negedge clk);
    end
    chk("rst_mid_no_done", 32'(n_done), 32'd0);
    do_read("rst_mid_sum", r);
    do_conv("rst_mid_zero", 32'd0, 32'd0, 0, r);
    chk("rst_mid_zero_const", r, 32'd0);
    force dut.sum_q = 32'hFFFF_F000;
    @(negedge clk);
    release dut.sum_q;
    m_sum = 64'hFFFF_F000;
    do_conv("near_sat", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, r);
    do_read("near_sat_sum", r);
    chk("near_sat_sum_const", r, 32'hFFFF_F3E8);
    force dut.sum_q = 32'hFFFF_FE00;
    @(negedge clk);
    release dut.sum_q;
    m_sum = 64'hFFFF_FE00;
    do_conv("sat1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, r);
    chk("sat1_const", r, 32'hFAFA_FAFA);
    do_conv("sat2", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, r);
    do_read("sat_sum", r);
    chk("sat_sum_const", r, 32'hFFFF_FFFF);
    do_conv("b2b_1", $urandom, $urandom, 0, r);
    do_conv("b2b_2", $urandom, $urandom, 0, r);
    do_conv("glitch", $urandom, $urandom, 2, r);
    do_read("glitch_sum", r);
    repeat (40) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 6) do_conv("rnd_conv", $urandom, $urandom, 0, r);
      else if (sel < 9) do_read("rnd_read", r);
      else do_bad("rnd_bad");
    end
    do_read("final_sum", r);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
